// File: rtl/pgm_pkg.sv
// Shared types and defaults for the packet generator scheduler.
// Holds the FSM encoding and parameter defaults.
package pgm_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int GAP_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pgm_dcnt.sv
// Loadable down-counter shared by the gap and read-timeout phases.
// Ports: load_i/val_i load, dec_i decrement, last_o when count is 1.
module pgm_dcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Count N covers N cycles in the phase: the Nth cycle sees 1.
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/pgm_sched.sv
// Packet generator scheduler: paces rd_start pulses to a RAM reader.
// Ports: cfg_* config, rd_start/rd_done reader handshake, sent_* status.
module pgm_sched
  import pgm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_W   = GAP_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_pkt_num,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             cfg_en,
  input  logic             pkt_stored,
  input  logic             in_alf,
  output logic             rd_start,
  input  logic             rd_done,
  output logic             sent_start_flag,
  output logic             sent_finish_flag,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = imax(GAP_W, TW);
  localparam logic [DW-1:0] TO_V = DW'(TIMEOUT);

  state_e           state_q;
  state_e           state_d;
  logic             rd_start_q;
  logic             start_q;
  logic             fin_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] pkt_num_q;
  logic [GAP_W-1:0] gap_q;
  logic             rearm_q;

  logic             dc_load;
  logic             dc_dec;
  logic [DW-1:0]    dc_val;
  logic             dc_last;
  logic [CNT_W-1:0] cnt_inc;
  logic             pkt_hit;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign pkt_hit = (pkt_num_q != '0) && (cnt_inc == pkt_num_q);

  // ARM keeps the timeout preloaded; rd_done swaps in the gap length.
  assign dc_load = (state_q == S_ARM)
                || ((state_q == S_WAIT) && rd_done);
  assign dc_val  = (state_q == S_ARM) ? TO_V : DW'(gap_q);
  assign dc_dec  = (state_q == S_WAIT) || (state_q == S_GAP);

  pgm_dcnt #(
    .W (DW)
  ) u_dcnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (dc_load),
    .dec_i  (dc_dec),
    .val_i  (dc_val),
    .last_o (dc_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_en && pkt_stored && rearm_q) state_d = S_ARM;
      end
      S_ARM: begin
        if (!cfg_en)      state_d = S_FIN;
        else if (!in_alf) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rd_done) begin
          if (pkt_hit)           state_d = S_FIN;
          else if (!cfg_en)      state_d = S_FIN;
          else if (gap_q != '0)  state_d = S_GAP;
          else                   state_d = S_ARM;
        end else if (dc_last) begin
          state_d = S_FIN;
        end
      end
      S_GAP: begin
        if (!cfg_en)      state_d = S_FIN;
        else if (dc_last) state_d = S_ARM;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_start_q <= 1'b0;
      start_q    <= 1'b0;
      fin_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      pkt_num_q  <= '0;
      gap_q      <= '0;
      rearm_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_start_q <= (state_q == S_ARM) && (state_d == S_WAIT);
      fin_q      <= (state_d == S_FIN);

      if ((state_q == S_IDLE) && cfg_load) begin
        pkt_num_q <= cfg_pkt_num;
        gap_q     <= cfg_gap;
      end

      // A session may only start after cfg_en was seen low in IDLE.
      if ((state_q == S_IDLE) && !cfg_en) rearm_q <= 1'b1;
      else if (state_d == S_FIN)          rearm_q <= 1'b0;

      if ((state_q == S_IDLE) && (state_d == S_ARM)) begin
        cnt_q   <= '0;
        err_q   <= 1'b0;
        start_q <= 1'b1;
      end else if (state_d == S_FIN) begin
        start_q <= 1'b0;
      end

      if ((state_q == S_WAIT) && rd_done) cnt_q <= cnt_inc;

      if ((state_q == S_WAIT) && !rd_done && dc_last) err_q <= 1'b1;
    end
  end

  assign rd_start         = rd_start_q;
  assign sent_start_flag  = start_q;
  assign sent_finish_flag = fin_q;
  assign sent_cnt         = cnt_q;
  assign err_timeout      = err_q;

endmodule

// File: tb/tb_pgm_sched.sv
// Self-checking bench for pgm_sched with a timing model of sessions.
// Drives config, models the RAM reader, checks pulse spacing and counts.
module tb_pgm_sched;

  localparam int CNT_W   = 32;
  localparam int GAP_W   = 16;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_load = 1'b0;
  logic [CNT_W-1:0] cfg_pkt_num = '0;
  logic [GAP_W-1:0] cfg_gap = '0;
  logic             cfg_en = 1'b0;
  logic             pkt_stored = 1'b0;
  logic             in_alf = 1'b0;
  logic             rd_start;
  logic             rd_done;
  logic             sent_start_flag;
  logic             sent_finish_flag;
  logic [CNT_W-1:0] sent_cnt;
  logic             err_timeout;

  logic rdr_auto = 1'b1;
  logic auto_done = 1'b0;
  logic rd_force = 1'b0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int starts[$];
  int dones[$];
  int nfin = 0;
  int due = -1;
  int rdr_delay = 4;

  assign rd_done = rdr_auto ? auto_done : rd_force;

  pgm_sched #(
    .CNT_W   (CNT_W),
    .GAP_W   (GAP_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_load         (cfg_load),
    .cfg_pkt_num      (cfg_pkt_num),
    .cfg_gap          (cfg_gap),
    .cfg_en           (cfg_en),
    .pkt_stored       (pkt_stored),
    .in_alf           (in_alf),
    .rd_start         (rd_start),
    .rd_done          (rd_done),
    .sent_start_flag  (sent_start_flag),
    .sent_finish_flag (sent_finish_flag),
    .sent_cnt         (sent_cnt),
    .err_timeout      (err_timeout)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log plus reader model: rd_done rdr_delay cycles after rd_start.
  initial forever begin
    @(negedge clk);
    if (rd_start === 1'b1) begin
      starts.push_back(cyc);
      due = cyc + rdr_delay;
    end
    if (rd_done === 1'b1) dones.push_back(cyc);
    if (sent_finish_flag === 1'b1) nfin++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    auto_done = (due == cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_session(input int n, input int g);
    tick(1);
    cfg_en = 1'b0;
    cfg_load = 1'b1;
    cfg_pkt_num = CNT_W'(n);
    cfg_gap = GAP_W'(g);
    tick(1);
    cfg_load = 1'b0;
    starts.delete();
    dones.delete();
    nfin = 0;
    cfg_en = 1'b1;
    pkt_stored = 1'b1;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k;
    k = 0;
    while (starts.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (starts.size() < n) begin
      errors++;
      $display("FAIL wait_starts: got %0d starts want %0d",
               starts.size(), n);
    end
  endtask

  task automatic wait_fin(input int budget, output int fc);
    int k;
    k = 0;
    fc = -1;
    while (sent_finish_flag !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (sent_finish_flag !== 1'b1) begin
      errors++;
      $display("FAIL wait_fin: no finish within %0d cycles", budget);
    end else begin
      fc = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if (rd_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd_start: got %b want 0", rd_start);
    end
    checks++;
    if (sent_start_flag !== 1'b0 || sent_finish_flag !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b%b want 00",
               sent_start_flag, sent_finish_flag);
    end
    checks++;
    if (sent_cnt !== '0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_cnt_err: got %0d/%b want 0/0",
               sent_cnt, err_timeout);
    end
    rst = 1'b0;
    tick(1);
    starts.delete();
    cfg_en = 1'b1;
    pkt_stored = 1'b0;
    tick(6);
    checks++;
    if (sent_start_flag !== 1'b0 || starts.size() != 0) begin
      errors++;
      $display("FAIL no_template: got flag %b starts %0d want 0 0",
               sent_start_flag, starts.size());
    end
    cfg_en = 1'b0;
    tick(1);
  endtask

  task automatic test_finite();
    int fc;
    rdr_auto = 1'b1;
    rdr_delay = 4;
    start_session(3, 0);
    wait_fin(60, fc);
    checks++;
    if (starts.size() != 3) begin
      errors++;
      $display("FAIL fin_starts: got %0d want 3", starts.size());
    end
    checks++;
    if (sent_cnt !== 32'd3) begin
      errors++;
      $display("FAIL fin_cnt: got %0d want 3", sent_cnt);
    end
    tick(30);
    checks++;
    if (starts.size() != 3 || nfin != 1) begin
      errors++;
      $display("FAIL fin_quiet: got starts %0d fins %0d want 3 1",
               starts.size(), nfin);
    end
    checks++;
    if (sent_start_flag !== 1'b0) begin
      errors++;
      $display("FAIL fin_flag: got %b want 0", sent_start_flag);
    end
  endtask

  task automatic test_gap_timing();
    int fc;
    rdr_auto = 1'b1;
    rdr_delay = 4;
    start_session(2, 3);
    wait_fin(60, fc);
    checks++;
    if (starts.size() != 2 || dones.size() != 2) begin
      errors++;
      $display("FAIL gap_events: got %0d/%0d want 2/2",
               starts.size(), dones.size());
    end else if (starts[1] - dones[0] != 5) begin
      errors++;
      $display("FAIL gap_spacing: got %0d want 5",
               starts[1] - dones[0]);
    end
  endtask

  task automatic test_random_sessions();
    int n, g, d, fc, step;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 5));
      g = int'($urandom_range(0, 6));
      d = int'($urandom_range(1, 8));
      step = d + g + 2;
      rdr_auto = 1'b1;
      rdr_delay = d;
      start_session(n, g);
      wait_fin(n * step + 20, fc);
      tick(step + 4);
      checks++;
      if (starts.size() != n || nfin != 1) begin
        errors++;
        $display("FAIL rnd_count n=%0d: got %0d starts %0d fins",
                 n, starts.size(), nfin);
      end else begin
        for (int k = 1; k < n; k++) begin
          checks++;
          if (starts[k] - starts[k-1] != step) begin
            errors++;
            $display("FAIL rnd_step g=%0d d=%0d: got %0d want %0d",
                     g, d, starts[k] - starts[k-1], step);
          end
        end
        checks++;
        if (fc != starts[n-1] + d + 1) begin
          errors++;
          $display("FAIL rnd_fin_cyc: got %0d want %0d",
                   fc, starts[n-1] + d + 1);
        end
      end
      checks++;
      if (sent_cnt !== CNT_W'(n) || err_timeout !== 1'b0) begin
        errors++;
        $display("FAIL rnd_cnt: got %0d/%b want %0d/0",
                 sent_cnt, err_timeout, n);
      end
    end
  endtask

  task automatic test_backpressure();
    int fc, c;
    rdr_auto = 1'b1;
    rdr_delay = 4;
    in_alf = 1'b1;
    start_session(1, 0);
    tick(20);
    checks++;
    if (starts.size() != 0 || sent_start_flag !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got starts %0d flag %b want 0 1",
               starts.size(), sent_start_flag);
    end
    in_alf = 1'b0;
    c = cyc;
    tick(2);
    in_alf = 1'b1;
    checks++;
    if (starts.size() != 1) begin
      errors++;
      $display("FAIL bp_release: got %0d starts want 1",
               starts.size());
    end else if (starts[0] != c + 1) begin
      errors++;
      $display("FAIL bp_latency: got %0d want %0d", starts[0], c + 1);
    end
    wait_fin(20, fc);
    checks++;
    if (sent_cnt !== 32'd1) begin
      errors++;
      $display("FAIL bp_complete: got %0d want 1", sent_cnt);
    end
    in_alf = 1'b0;
    tick(2);
  endtask

  task automatic test_timeout();
    int fc;
    rdr_auto = 1'b0;
    rd_force = 1'b0;
    start_session(1, 0);
    wait_fin(60, fc);
    checks++;
    if (starts.size() != 1) begin
      errors++;
      $display("FAIL to_start: got %0d want 1", starts.size());
    end else if (fc - starts[0] != TIMEOUT) begin
      errors++;
      $display("FAIL to_len: got %0d want %0d",
               fc - starts[0], TIMEOUT);
    end
    checks++;
    if (err_timeout !== 1'b1 || sent_start_flag !== 1'b0) begin
      errors++;
      $display("FAIL to_flags: got err %b start %b want 1 0",
               err_timeout, sent_start_flag);
    end
    tick(4);
    checks++;
    if (err_timeout !== 1'b1 || nfin != 1 || starts.size() != 1) begin
      errors++;
      $display("FAIL to_idle: got err %b fins %0d starts %0d",
               err_timeout, nfin, starts.size());
    end
    rdr_auto = 1'b1;
    start_session(1, 0);
    tick(2);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: got %b want 0", err_timeout);
    end
    wait_fin(30, fc);
    tick(1);
  endtask

  task automatic test_continuous();
    int fc;
    rdr_auto = 1'b1;
    rdr_delay = 5;
    start_session(0, 1);
    wait_starts(3, 60);
    cfg_load = 1'b1;
    cfg_pkt_num = 32'd4;
    cfg_gap = 16'd9;
    pkt_stored = 1'b0;
    tick(1);
    cfg_load = 1'b0;
    wait_starts(5, 60);
    checks++;
    if (starts.size() >= 5 && starts[4] - starts[3] != 8) begin
      errors++;
      $display("FAIL cont_step: got %0d want 8", starts[4] - starts[3]);
    end
    checks++;
    if (nfin != 0 || sent_start_flag !== 1'b1) begin
      errors++;
      $display("FAIL cont_alive: got fins %0d flag %b want 0 1",
               nfin, sent_start_flag);
    end
    wait_starts(6, 30);
    tick(2);
    cfg_en = 1'b0;
    wait_fin(20, fc);
    checks++;
    if (dones.size() != 6) begin
      errors++;
      $display("FAIL cont_dones: got %0d want 6", dones.size());
    end else if (fc != dones[5] + 1) begin
      errors++;
      $display("FAIL cont_fin_cyc: got %0d want %0d", fc, dones[5] + 1);
    end
    checks++;
    if (sent_cnt !== 32'd6) begin
      errors++;
      $display("FAIL cont_cnt: got %0d want 6", sent_cnt);
    end
    pkt_stored = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid_wait();
    rdr_auto = 1'b0;
    rd_force = 1'b0;
    start_session(2, 0);
    wait_starts(1, 20);
    rd_force = 1'b1;
    tick(1);
    rd_force = 1'b0;
    wait_starts(2, 20);
    checks++;
    if (sent_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rw_pre: got %0d want 1", sent_cnt);
    end
    rst = 1'b1;
    cfg_en = 1'b0;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({rd_start, sent_start_flag, sent_finish_flag, err_timeout}
        !== 4'b0000 || sent_cnt !== '0) begin
      errors++;
      $display("FAIL rw_outs: got %b%b%b%b cnt %0d want 0000 0",
               rd_start, sent_start_flag, sent_finish_flag,
               err_timeout, sent_cnt);
    end
    rd_force = 1'b1;
    tick(1);
    rd_force = 1'b0;
    tick(3);
    checks++;
    if (sent_cnt !== '0 || nfin != 0 || starts.size() != 2) begin
      errors++;
      $display("FAIL rw_ignore: got cnt %0d fins %0d starts %0d",
               sent_cnt, nfin, starts.size());
    end
    rdr_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_finite();
    test_gap_timing();
    test_random_sessions();
    test_backpressure();
    test_timeout();
    test_continuous();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
